// File: rtl/reg_bank_swap_ctrl.sv
// Register bank with read/write/swap transfer engine and one-hot access strobe.
// Optional macro REGC_BUS_HOLD_EN keeps bus_out at the last READ value instead of clearing it.
module reg_bank_swap_ctrl #(
  parameter int DATA_W = 18,
  parameter int ADDR_W = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [1:0]           op,
  input  logic [ADDR_W-1:0]    addr_a,
  input  logic [ADDR_W-1:0]    addr_b,
  input  logic [DATA_W-1:0]    bus_in,
  output logic [DATA_W-1:0]    bus_out,
  output logic [2**ADDR_W-1:0] en_onehot,
  output logic                 busy,
  output logic                 done,
  input  logic [ADDR_W-1:0]    rd_addr,
  output logic [DATA_W-1:0]    rd_data
);

  localparam int NUM_REGS = 2**ADDR_W;

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_WRITE = 2'b10;
  localparam logic [1:0] OP_SWAP  = 2'b11;

  typedef enum logic [1:0] {IDLE, SW1, SW2} state_t;

  state_t              state;
  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [DATA_W-1:0]   tmp;
  logic [ADDR_W-1:0]   sw_a;
  logic [ADDR_W-1:0]   sw_b;

  function automatic logic [NUM_REGS-1:0] onehot(input logic [ADDR_W-1:0] a);
    logic [NUM_REGS-1:0] v;
    v    = '0;
    v[a] = 1'b1;
    return v;
  endfunction

  assign rd_data = regs[rd_addr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      bus_out   <= '0;
      tmp       <= '0;
      sw_a      <= '0;
      sw_b      <= '0;
      en_onehot <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      state     <= IDLE;
    end else begin
      en_onehot <= '0;
      done      <= 1'b0;
`ifndef REGC_BUS_HOLD_EN
      bus_out   <= '0;
`endif
      case (state)
        IDLE: begin
          if (start) begin
            case (op)
              OP_READ: begin
                bus_out   <= regs[addr_a];
                en_onehot <= onehot(addr_a);
                done      <= 1'b1;
              end
              OP_WRITE: begin
                regs[addr_a] <= bus_in;
                en_onehot    <= onehot(addr_a);
                done         <= 1'b1;
              end
              OP_SWAP: begin
                tmp   <= regs[addr_a];
                sw_a  <= addr_a;
                sw_b  <= addr_b;
                busy  <= 1'b1;
                state <= SW1;
              end
              OP_NOP: ;
              default: ;
            endcase
          end
        end
        SW1: begin
          regs[sw_a] <= regs[sw_b];
          en_onehot  <= onehot(sw_a);
          state      <= SW2;
        end
        SW2: begin
          // tmp holds the original reg[a], so a==b writes back its own value
          regs[sw_b] <= tmp;
          en_onehot  <= onehot(sw_b);
          busy       <= 1'b0;
          done       <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_bank_swap_ctrl.sv
// Bench for reg_bank_swap_ctrl: directed vector table, async reset check, randomized run vs model.
module tb_reg_bank_swap_ctrl;
  localparam int DW = 18;
  localparam int AW = 3;
  localparam int NR = 8;
`ifdef REGC_BUS_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  logic          clk, rst, start, busy, done;
  logic [1:0]    op;
  logic [AW-1:0] addr_a, addr_b, rd_addr;
  logic [DW-1:0] bus_in, bus_out, rd_data;
  logic [NR-1:0] en_onehot;

  int total = 0;
  int bad   = 0;

  reg_bank_swap_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .addr_a(addr_a), .addr_b(addr_b),
    .bus_in(bus_in), .bus_out(bus_out), .en_onehot(en_onehot), .busy(busy), .done(done),
    .rd_addr(rd_addr), .rd_data(rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          s;
    logic [1:0]    op;
    logic [AW-1:0] a, b;
    logic [DW-1:0] din;
    logic [AW-1:0] ra;
    logic [DW-1:0] ebus;
    logic [NR-1:0] een;
    logic          ebusy, edone;
    logic [DW-1:0] erd;
  } vec_t;

  vec_t vt[15];

  function automatic vec_t mk(input logic s, input logic [1:0] o, input int a, input int b,
                              input logic [DW-1:0] din, input int ra, input logic [DW-1:0] ebus,
                              input logic [NR-1:0] een, input logic ebusy, input logic edone,
                              input logic [DW-1:0] erd);
    vec_t v;
    v.s = s; v.op = o; v.a = AW'(a); v.b = AW'(b); v.din = din; v.ra = AW'(ra);
    v.ebus = ebus; v.een = een; v.ebusy = ebusy; v.edone = edone; v.erd = erd;
    return v;
  endfunction

  function automatic logic [DW-1:0] hb(input logic [DW-1:0] v);
    return HOLD ? v : '0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic s, input logic [1:0] o, input logic [AW-1:0] a,
                       input logic [AW-1:0] b, input logic [DW-1:0] din, input logic [AW-1:0] ra);
    start = s; op = o; addr_a = a; addr_b = b; bus_in = din; rd_addr = ra;
  endtask

  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask

  // reference model: swap treated as an atomic exchange that lands on its third edge
  logic [DW-1:0] m [NR];
  logic [DW-1:0] mbus;
  int            rem;
  logic [AW-1:0] msa, msb;

  initial begin
    logic [NR-1:0] xen;
    logic          xdone;
    logic [DW-1:0] t;

    rst = 1'b1;
    drive(1'b0, 2'b00, '0, '0, '0, '0);
    @(negedge clk);
    chk("reset_bus", 32'(bus_out), 32'h0);
    chk("reset_en", 32'(en_onehot), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_done", 32'(done), 32'h0);
    step;
    rst = 1'b0;

    vt[0]  = mk(1, 2'b10, 5, 0, 18'h2ABCD, 5, 18'h0, 8'h20, 0, 1, 18'h2ABCD);
    vt[1]  = mk(1, 2'b01, 5, 0, 18'h0, 5, 18'h2ABCD, 8'h20, 0, 1, 18'h2ABCD);
    vt[2]  = mk(0, 2'b01, 5, 0, 18'h0, 5, hb(18'h2ABCD), 8'h00, 0, 0, 18'h2ABCD);
    vt[3]  = mk(1, 2'b10, 2, 0, 18'h00011, 2, hb(18'h2ABCD), 8'h04, 0, 1, 18'h00011);
    vt[4]  = mk(1, 2'b10, 7, 0, 18'h3FFFF, 7, hb(18'h2ABCD), 8'h80, 0, 1, 18'h3FFFF);
    vt[5]  = mk(1, 2'b11, 2, 7, 18'h0, 2, hb(18'h2ABCD), 8'h00, 1, 0, 18'h00011);
    vt[6]  = mk(1, 2'b10, 0, 1, 18'h15555, 2, hb(18'h2ABCD), 8'h04, 1, 0, 18'h3FFFF);
    vt[7]  = mk(1, 2'b10, 3, 4, 18'h00001, 2, hb(18'h2ABCD), 8'h80, 0, 1, 18'h3FFFF);
    vt[8]  = mk(0, 2'b00, 0, 0, 18'h0, 7, hb(18'h2ABCD), 8'h00, 0, 0, 18'h00011);
    vt[9]  = mk(1, 2'b00, 0, 0, 18'h1, 0, hb(18'h2ABCD), 8'h00, 0, 0, 18'h0);
    vt[10] = mk(1, 2'b10, 3, 0, 18'h12345, 3, hb(18'h2ABCD), 8'h08, 0, 1, 18'h12345);
    vt[11] = mk(1, 2'b11, 3, 3, 18'h0, 3, hb(18'h2ABCD), 8'h00, 1, 0, 18'h12345);
    vt[12] = mk(0, 2'b00, 0, 0, 18'h0, 3, hb(18'h2ABCD), 8'h08, 1, 0, 18'h12345);
    vt[13] = mk(0, 2'b00, 0, 0, 18'h0, 3, hb(18'h2ABCD), 8'h08, 0, 1, 18'h12345);
    vt[14] = mk(1, 2'b01, 7, 0, 18'h0, 3, 18'h00011, 8'h80, 0, 1, 18'h12345);

    for (int i = 0; i < 15; i++) begin
      drive(vt[i].s, vt[i].op, vt[i].a, vt[i].b, vt[i].din, vt[i].ra);
      step;
      chk($sformatf("vec%0d_bus", i), 32'(bus_out), 32'(vt[i].ebus));
      chk($sformatf("vec%0d_en", i), 32'(en_onehot), 32'(vt[i].een));
      chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vt[i].ebusy));
      chk($sformatf("vec%0d_done", i), 32'(done), 32'(vt[i].edone));
      chk($sformatf("vec%0d_rd", i), 32'(rd_data), 32'(vt[i].erd));
    end

    // async reset while the swap sits in SW1
    drive(1'b1, 2'b11, 3'd2, 3'd7, '0, 3'd2);
    step;
    chk("arst_pre_busy", 32'(busy), 32'h1);
    drive(1'b0, 2'b00, '0, '0, '0, '0);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", 32'(busy), 32'h0);
    chk("arst_done", 32'(done), 32'h0);
    chk("arst_en", 32'(en_onehot), 32'h0);
    for (int i = 0; i < NR; i++) begin
      rd_addr = AW'(i);
      #1;
      chk($sformatf("arst_rd%0d", i), 32'(rd_data), 32'h0);
    end
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 2'b01, 3'd2, '0, '0, 3'd2);
    step;
    chk("arst_read_bus", 32'(bus_out), 32'h0);
    chk("arst_read_en", 32'(en_onehot), 32'h04);
    chk("arst_read_done", 32'(done), 32'h1);

    // randomized run against the model
    rst = 1'b1;
    drive(1'b0, 2'b00, '0, '0, '0, '0);
    step;
    rst = 1'b0;
    for (int i = 0; i < NR; i++) m[i] = '0;
    mbus = '0;
    rem  = 0;
    msa  = '0;
    msb  = '0;
    for (int n = 0; n < 600; n++) begin
      drive(($urandom % 4) != 0, 2'($urandom), AW'($urandom), AW'($urandom),
            DW'($urandom), AW'($urandom));
      xen   = '0;
      xdone = 1'b0;
      if (!HOLD) mbus = '0;
      if (rem == 0) begin
        if (start) begin
          case (op)
            2'b01: begin mbus = m[addr_a]; xen = NR'(1) << addr_a; xdone = 1'b1; end
            2'b10: begin m[addr_a] = bus_in; xen = NR'(1) << addr_a; xdone = 1'b1; end
            2'b11: begin msa = addr_a; msb = addr_b; rem = 2; end
            default: ;
          endcase
        end
      end else if (rem == 2) begin
        xen = NR'(1) << msa;
        rem = 1;
      end else begin
        t = m[msa]; m[msa] = m[msb]; m[msb] = t;
        xen = NR'(1) << msb;
        xdone = 1'b1;
        rem = 0;
      end
      step;
      chk("rnd_bus", 32'(bus_out), 32'(mbus));
      chk("rnd_en", 32'(en_onehot), 32'(xen));
      chk("rnd_busy", 32'(busy), 32'(rem != 0));
      chk("rnd_done", 32'(done), 32'(xdone));
      if (rem == 0) chk("rnd_rd", 32'(rd_data), 32'(m[rd_addr]));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
